// File: rtl/fwd_pkg.sv
// fwd_pkg: forward-select encodings and pipeline shadow-stage type shared by the forwarding controller.
package fwd_pkg;
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  // rd is held at a fixed width wide enough for any supported REG_AW
  localparam int RD_W = 8;
  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic            rw;
    logic            v;
  } shadow_t;
  function automatic logic fwd_hit(input shadow_t s, input logic [RD_W-1:0] src);
    return s.v && s.rw && (s.rd != '0) && (s.rd == src);
  endfunction
endpackage

// File: rtl/fwd_sel.sv
// fwd_sel: operand forward-select comparator; the EX/MEM hit takes priority over the MEM/WB hit.
module fwd_sel
  import fwd_pkg::*;
(
  input  logic [RD_W-1:0] src,
  input  shadow_t         mem,
  input  shadow_t         wb,
  output logic [1:0]      sel
);
  always_comb sel = fwd_hit(mem, src) ? FWD_EXMEM : fwd_hit(wb, src) ? FWD_MEMWB : FWD_REG;
endmodule

// File: rtl/fwd_ctrl.sv
// fwd_ctrl: forwarding and load-use hazard controller with EX/MEM/WB shadow registers.
// Optional stall counter on stall_cnt is built when FWD_STATS_EN is defined.
module fwd_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int REG_N  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              stall,
  output logic [15:0]       stall_cnt
);
  if (REG_AW > RD_W || REG_N > 2 ** REG_AW) begin : g_bad_cfg
    $error("fwd_ctrl: REG_AW/REG_N out of range");
  end
  shadow_t         ex, mem, wb;
  logic [RD_W-1:0] ex_rs, ex_rt, rs, rt, rd;
  logic            ex_mr, load;
  assign rs = RD_W'(id_rs);
  assign rt = RD_W'(id_rt);
  assign rd = RD_W'(id_rd);
  // flush suppresses the stall so the flushed consumer simply disappears as a bubble
  assign stall = ex.v && ex_mr && (ex.rd != '0) && id_valid && !flush && (ex.rd == rs || ex.rd == rt);
  assign load  = id_valid && !flush && !stall;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex    <= '0;
      mem   <= '0;
      wb    <= '0;
      ex_rs <= '0;
      ex_rt <= '0;
      ex_mr <= 1'b0;
    end else begin
      wb    <= mem;
      mem   <= ex;
      ex    <= load ? shadow_t'{rd: rd, rw: id_reg_write, v: 1'b1} : '0;
      ex_rs <= load ? rs : '0;
      ex_rt <= load ? rt : '0;
      ex_mr <= load && id_mem_read;
    end
  end
  fwd_sel u_sel_a (.src(ex_rs), .mem(mem), .wb(wb), .sel(forward_a));
  fwd_sel u_sel_b (.src(ex_rt), .mem(mem), .wb(wb), .sel(forward_b));
`ifdef FWD_STATS_EN
  logic [15:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (stall && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
  end
  assign stall_cnt = cnt;
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_fwd_ctrl.sv
// tb_fwd_ctrl: table-driven pipeline sequences with a scoreboard queue, plus an async-reset-mid-stall sequence.
module tb_fwd_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        id_valid = 1'b0, id_reg_write = 1'b0, id_mem_read = 1'b0, flush = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
  logic [1:0]  forward_a, forward_b;
  logic        stall;
  logic [15:0] stall_cnt;
  int          n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  fwd_ctrl #(.REG_AW(5), .REG_N(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .forward_a(forward_a), .forward_b(forward_b), .stall(stall), .stall_cnt(stall_cnt)
  );
  typedef struct {
    logic       v;
    logic [4:0] rs, rt, rd;
    logic       rw, mr, fl;
    logic [1:0] ea, eb;
    logic       es;
  } vec_t;
  typedef struct {
    int         idx;
    logic [1:0] a, b;
    logic       s;
    logic [15:0] c;
  } exp_t;
  vec_t        vt[$];
  exp_t        sb[$];
  logic [15:0] exp_cnt = '0;
  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic add(input logic v, input int rs, input int rt, input int rd, input logic rw, input logic mr,
                     input logic fl, input int ea, input int eb, input logic es);
    vec_t x;
    x.v = v; x.rs = 5'(rs); x.rt = 5'(rt); x.rd = 5'(rd);
    x.rw = rw; x.mr = mr; x.fl = fl;
    x.ea = 2'(ea); x.eb = 2'(eb); x.es = es;
    vt.push_back(x);
  endtask
  task automatic drive(input logic v, input int rs, input int rt, input int rd, input logic rw, input logic mr,
                       input logic fl);
    id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_rd = 5'(rd);
    id_reg_write = rw; id_mem_read = mr; flush = fl;
  endtask
  function automatic logic [15:0] cnt_model(input logic [15:0] c, input logic s);
`ifdef FWD_STATS_EN
    return (s && c != 16'hFFFF) ? c + 16'd1 : c;
`else
    return (s && 1'b0) ? c : 16'h0000;
`endif
  endfunction
  initial begin
    exp_t e;
    //   v rs rt rd rw mr fl  ea eb es
    add(1, 1, 2, 3, 1, 0, 0, 0, 0, 0);
    add(1, 3, 4, 6, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    add(1, 1, 5, 8, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 9, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 10, 1, 0, 0, 0, 0, 0);
    add(1, 0, 9, 11, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 2, 0);
    add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 12, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    add(1, 0, 0, 12, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 7, 1, 1, 0, 0, 0, 0);
    add(1, 2, 7, 13, 1, 0, 0, 0, 0, 1);
    add(1, 2, 7, 13, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 2, 0);
    add(1, 0, 0, 4, 1, 1, 0, 0, 0, 0);
    add(1, 4, 0, 15, 1, 1, 1, 0, 0, 0);
    add(1, 15, 15, 16, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 20, 1, 1, 0, 0, 0, 0);
    add(1, 20, 0, 21, 1, 1, 0, 0, 0, 1);
    add(1, 20, 0, 21, 1, 1, 0, 0, 0, 0);
    add(1, 21, 0, 22, 1, 0, 0, 2, 0, 1);
    add(1, 21, 0, 22, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 2, 0, 0);
    drive(1, 7, 7, 7, 1, 1, 0);
    #12;
    chk("reset_fwd_a", forward_a, 0);
    chk("reset_fwd_b", forward_b, 0);
    chk("reset_stall", stall, 0);
    chk("reset_cnt", stall_cnt, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    foreach (vt[i]) begin
      @(posedge clk);
      #1 drive(vt[i].v, vt[i].rs, vt[i].rt, vt[i].rd, vt[i].rw, vt[i].mr, vt[i].fl);
      sb.push_back('{i, vt[i].ea, vt[i].eb, vt[i].es, exp_cnt});
      exp_cnt = cnt_model(exp_cnt, vt[i].es);
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("v%0d_fwd_a", e.idx), forward_a, e.a);
      chk($sformatf("v%0d_fwd_b", e.idx), forward_b, e.b);
      chk($sformatf("v%0d_stall", e.idx), stall, e.s);
      chk($sformatf("v%0d_cnt", e.idx), stall_cnt, e.c);
    end
    // add r2; lw r7 <- r2; consumer of r7: stalls while the load shows an EX/MEM forward of r2
    @(posedge clk); #1 drive(1, 0, 0, 2, 1, 0, 0);
    @(posedge clk); #1 drive(1, 2, 0, 7, 1, 1, 0);
    @(posedge clk); #1 drive(1, 0, 7, 9, 1, 0, 0);
    @(negedge clk);
    chk("pre_rst_fwd_a", forward_a, 1);
    chk("pre_rst_stall", stall, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_fwd_a", forward_a, 0);
    chk("async_rst_fwd_b", forward_b, 0);
    chk("async_rst_stall", stall, 0);
    chk("async_rst_cnt", stall_cnt, 0);
    drive(1, 2, 7, 9, 1, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("post_rst_stall", stall, 0);
    @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("post_rst_fwd_a", forward_a, 0);
    chk("post_rst_fwd_b", forward_b, 0);
    chk("post_rst_cnt", stall_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
